// File: rtl/fifo_pkt_writer_pkg.sv
// Shared framing definitions for the packet writer and the read-side deframer.
package fifo_pkt_pkg;

  typedef enum logic [2:0] {IDLE, SEQ, PAY, CHK, DROP} state_e;

  localparam logic [7:0] SOF_WORD_DEF = 8'hA5;
  localparam int         CHK_MAX_W    = 64;

  // Running check word; callers zero-extend to CHK_MAX_W and truncate back.
  function automatic logic [CHK_MAX_W-1:0] chk_acc(input logic [CHK_MAX_W-1:0] chk,
                                                   input logic [CHK_MAX_W-1:0] word);
    return chk ^ word;
  endfunction

endpackage

// File: rtl/fifo_pkt_writer_if.sv
// Producer stream plus FIFO write port, as seen by the packet writer.
interface fifo_pkt_writer_if #(parameter int DATA_WIDTH = 8);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  w_full;
  logic                  w_inc;
  logic [DATA_WIDTH-1:0] w_data;

  modport master (output s_valid, s_data, s_last, w_full,
                  input  s_ready, w_inc, w_data);
  modport slave  (input  s_valid, s_data, s_last, w_full,
                  output s_ready, w_inc, w_data);
endinterface

// File: rtl/fifo_pkt_writer_out_reg.sv
// One-entry output register in front of the FIFO write port.
module pkt_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  ld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  trl_i,
  input  logic                  w_full_i,
  output logic                  load_ok_o,
  output logic                  w_inc_o,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic                  out_vld_o,
  output logic                  out_trl_o
);
  logic                  vld_q;
  logic                  trl_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign w_inc_o   = vld_q & ~w_full_i;
  assign load_ok_o = ~vld_q | w_inc_o;
  assign w_data_o  = data_q;
  assign out_vld_o = vld_q;
  assign out_trl_o = trl_q;

  // Data holds when the slot empties so w_data never glitches to junk.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      vld_q  <= 1'b0;
      trl_q  <= 1'b0;
      data_q <= '0;
    end else if (load_ok_o) begin
      vld_q <= ld_i;
      if (ld_i) begin
        data_q <= data_i;
        trl_q  <= trl_i;
      end
    end
  end
endmodule

// File: rtl/fifo_pkt_writer.sv
// Frames a valid/ready byte stream as SOF, SEQ, payload, CHK into the async FIFO write port.
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_WORD   = DATA_WIDTH'(SOF_WORD_DEF),
  localparam int                   LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                w_clk,
  input  logic                w_rst_n,
  input  logic                en,
  input  logic                err_clr,
  output logic                busy,
  output logic                pkt_done,
  output logic                err_trunc,
  fifo_pkt_writer_if.slave    bus
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] seq_q, seq_d, chk_q, chk_d;
  logic [LEN_W-1:0]      len_q, len_d, len_inc;
  logic                  trunc_q, trunc_d, err_q, err_d, err_set;
  logic                  s_ready, acc, ld, ld_trl, load_ok, out_vld, out_trl;
  logic [DATA_WIDTH-1:0] ld_data;

  assign len_inc = len_q + LEN_W'(1);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      chk_q   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      chk_q   <= chk_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      err_q   <= err_d;
    end
  end

  // Outputs: every register load is gated by load_ok, DROP swallows beats freely.
  always_comb begin
    s_ready = 1'b0;
    acc     = 1'b0;
    ld      = 1'b0;
    ld_trl  = 1'b0;
    ld_data = '0;
    case (state_q)
      IDLE: begin
        ld      = en & bus.s_valid & load_ok;
        ld_data = SOF_WORD;
      end
      SEQ: begin
        ld      = load_ok;
        ld_data = seq_q;
      end
      PAY: begin
        s_ready = load_ok;
        acc     = bus.s_valid & load_ok;
        ld      = acc;
        ld_data = bus.s_data;
      end
      CHK: begin
        ld      = load_ok;
        ld_data = chk_q;
        ld_trl  = 1'b1;
      end
      DROP: begin
        s_ready = 1'b1;
        acc     = bus.s_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    chk_d   = chk_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: if (ld) begin
        chk_d   = '0;
        len_d   = '0;
        state_d = SEQ;
      end
      SEQ: if (ld) state_d = PAY;
      PAY: if (acc) begin
        chk_d = DATA_WIDTH'(chk_acc(CHK_MAX_W'(chk_q), CHK_MAX_W'(bus.s_data)));
        len_d = len_inc;
        // s_last on the MAX_LEN-th word is a clean close, not a truncation.
        if (bus.s_last) begin
          trunc_d = 1'b0;
          state_d = CHK;
        end else if (len_inc == LEN_W'(MAX_LEN)) begin
          trunc_d = 1'b1;
          state_d = CHK;
        end
      end
      CHK: if (ld) begin
        seq_d   = seq_q + DATA_WIDTH'(1);
        err_set = trunc_q;
        state_d = trunc_q ? DROP : IDLE;
      end
      DROP: if (acc && bus.s_last) begin
        trunc_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr);
  end

  pkt_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .ld_i      (ld),
    .data_i    (ld_data),
    .trl_i     (ld_trl),
    .w_full_i  (bus.w_full),
    .load_ok_o (load_ok),
    .w_inc_o   (bus.w_inc),
    .w_data_o  (bus.w_data),
    .out_vld_o (out_vld),
    .out_trl_o (out_trl)
  );

  assign bus.s_ready = s_ready;
  assign busy        = (state_q != IDLE) | out_vld;
  assign pkt_done    = bus.w_inc & out_trl;
  assign err_trunc   = err_q;
endmodule
